// File: rtl/cache_mem_req_sched_pkg.sv
// Shared encodings for the cache-to-memory request scheduler:
// access-size codes carried on the *_type buses and the read FSM states.
package cache_mem_req_sched_pkg;

   localparam int ADDR_W  = 32;
   localparam int RDATA_W = 64;
   localparam int WDATA_W = 128;
   localparam int TYPE_W  = 3;
   localparam int STRB_W  = 8;

   localparam logic [TYPE_W-1:0] RD_TYPE_B1   = 3'd0;
   localparam logic [TYPE_W-1:0] RD_TYPE_B2   = 3'd1;
   localparam logic [TYPE_W-1:0] RD_TYPE_B4   = 3'd2;
   localparam logic [TYPE_W-1:0] RD_TYPE_B8   = 3'd3;
   localparam logic [TYPE_W-1:0] RD_TYPE_LINE = 3'd4;

   typedef enum logic [2:0] {
      RD_IDLE = 3'd0,
      I_ADDR  = 3'd1,
      D_ADDR  = 3'd2,
      I_DATA  = 3'd3,
      D_DATA  = 3'd4
   } rd_state_t;

endpackage

// File: rtl/cache_mem_req_sched_wr_hazard_tracker.sv
// Remembers the line of the single outstanding D-cache write and flags a
// D-cache read that targets that line until the write's B response arrives.
module wr_hazard_tracker #(
   parameter int LINE_W = 28
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_fire,
   input  logic [LINE_W-1:0] wr_line,
   input  logic              bdone,
   input  logic [LINE_W-1:0] rd_line,
   output logic              wr_pend,
   output logic              hazard
);

   logic [LINE_W-1:0] pend_line;

   // Pending flag: set on accept, cleared by the B response (never both at once).
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_pend <= 1'b0;
      end else if (wr_fire) begin
         wr_pend <= 1'b1;
      end else if (bdone) begin
         wr_pend <= 1'b0;
      end
   end

   // Captured line address; only meaningful while wr_pend is set, so no reset.
   always_ff @(posedge clk) begin
      if (wr_fire) begin
         pend_line <= wr_line;
      end
   end

   // Same-line compare against the outstanding write.
   always_comb begin
      hazard = wr_pend && (rd_line == pend_line);
   end

endmodule

// File: rtl/cache_mem_req_sched.sv
// Merges I-cache and D-cache reads onto one downstream read port (D priority
// with I anti-starvation) and forwards D-cache writes to the write port,
// holding back same-line D reads while a write is still unacknowledged.
module cache_mem_req_sched
   import cache_mem_req_sched_pkg::*;
#(
   parameter int STARVE_MAX = 8,
   parameter int LINE_OFS   = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ic_rd_req,
   input  logic [ADDR_W-1:0]  ic_rd_addr,
   input  logic [TYPE_W-1:0]  ic_rd_type,
   output logic               ic_rd_ready,
   output logic [RDATA_W-1:0] ic_rdata,
   output logic               ic_rlast,
   output logic               ic_rvalid,
   input  logic               dc_rd_req,
   input  logic [ADDR_W-1:0]  dc_rd_addr,
   input  logic [TYPE_W-1:0]  dc_rd_type,
   output logic               dc_rd_ready,
   output logic [RDATA_W-1:0] dc_rdata,
   output logic               dc_rlast,
   output logic               dc_rvalid,
   input  logic               dc_wr_req,
   input  logic [ADDR_W-1:0]  dc_wr_addr,
   input  logic [WDATA_W-1:0] dc_wdata,
   input  logic [TYPE_W-1:0]  dc_wr_type,
   input  logic [STRB_W-1:0]  dc_wstrb,
   output logic               dc_wr_ready,
   output logic               dn_rd_req,
   output logic [ADDR_W-1:0]  dn_rd_addr,
   output logic [TYPE_W-1:0]  dn_rd_type,
   input  logic               dn_rd_ready,
   input  logic [RDATA_W-1:0] dn_rdata,
   input  logic               dn_rlast,
   input  logic               dn_rvalid,
   output logic               dn_wr_req,
   output logic [ADDR_W-1:0]  dn_wr_addr,
   output logic [WDATA_W-1:0] dn_wdata,
   output logic [TYPE_W-1:0]  dn_wr_type,
   output logic [STRB_W-1:0]  dn_wstrb,
   input  logic               dn_wr_ready,
   input  logic               dn_wr_bdone
);

   localparam int CNT_W  = $clog2(STARVE_MAX + 1);
   localparam int LINE_W = ADDR_W - LINE_OFS;

   rd_state_t  state, next_state;
   logic [CNT_W-1:0] starve_cnt;
   logic       wr_pend, hazard, grant_d, grant_i;

   wr_hazard_tracker #(.LINE_W(LINE_W)) u_hazard (
      .clk     (clk),
      .rst     (rst),
      .wr_fire (dc_wr_req && dc_wr_ready),
      .wr_line (dc_wr_addr[ADDR_W-1:LINE_OFS]),
      .bdone   (dn_wr_bdone),
      .rd_line (dc_rd_addr[ADDR_W-1:LINE_OFS]),
      .wr_pend (wr_pend),
      .hazard  (hazard)
   );

   // Idle-state arbitration: D wins unless blocked or I has waited too long.
   always_comb begin
      grant_d = (state == RD_IDLE) && dc_rd_req && !hazard &&
                (!ic_rd_req || (starve_cnt < CNT_W'(STARVE_MAX)));
      grant_i = (state == RD_IDLE) && ic_rd_req && !grant_d;
   end

   // Read FSM state register.
   always_ff @(posedge clk) begin
      if (rst) state <= RD_IDLE;
      else     state <= next_state;
   end

   // Read FSM transitions.
   always_comb begin
      next_state = state;
      case (state)
         RD_IDLE: begin
            if (grant_d)      next_state = D_ADDR;
            else if (grant_i) next_state = I_ADDR;
         end
         I_ADDR: begin
            if (!ic_rd_req)       next_state = RD_IDLE;
            else if (dn_rd_ready) next_state = I_DATA;
         end
         D_ADDR: begin
            if (!dc_rd_req)       next_state = RD_IDLE;
            else if (dn_rd_ready) next_state = D_DATA;
         end
         I_DATA, D_DATA: begin
            if (dn_rvalid && dn_rlast) next_state = RD_IDLE;
         end
         default: next_state = RD_IDLE;
      endcase
   end

   // Read-side outputs: only the current owner is connected downstream.
   always_comb begin
      dn_rd_req   = 1'b0;
      dn_rd_addr  = '0;
      dn_rd_type  = '0;
      ic_rd_ready = 1'b0;
      dc_rd_ready = 1'b0;
      ic_rdata    = '0;
      ic_rlast    = 1'b0;
      ic_rvalid   = 1'b0;
      dc_rdata    = '0;
      dc_rlast    = 1'b0;
      dc_rvalid   = 1'b0;
      case (state)
         I_ADDR: begin
            dn_rd_req   = ic_rd_req;
            dn_rd_addr  = ic_rd_addr;
            dn_rd_type  = ic_rd_type;
            ic_rd_ready = dn_rd_ready;
         end
         D_ADDR: begin
            dn_rd_req   = dc_rd_req;
            dn_rd_addr  = dc_rd_addr;
            dn_rd_type  = dc_rd_type;
            dc_rd_ready = dn_rd_ready;
         end
         I_DATA: begin
            ic_rdata  = dn_rdata;
            ic_rlast  = dn_rlast;
            ic_rvalid = dn_rvalid;
         end
         D_DATA: begin
            dc_rdata  = dn_rdata;
            dc_rlast  = dn_rlast;
            dc_rvalid = dn_rvalid;
         end
         default: ;
      endcase
   end

   // Anti-starvation count of D grants taken while I was waiting.
   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (state == RD_IDLE) begin
         if (!ic_rd_req || grant_i) begin
            starve_cnt <= '0;
         end else if (grant_d && (starve_cnt != CNT_W'(STARVE_MAX))) begin
            starve_cnt <= starve_cnt + 1'b1;
         end
      end
   end

   // Write path is a straight pass-through, throttled to one outstanding write.
   always_comb begin
      dn_wr_req   = dc_wr_req && !wr_pend;
      dn_wr_addr  = dc_wr_addr;
      dn_wdata    = dc_wdata;
      dn_wr_type  = dc_wr_type;
      dn_wstrb    = dc_wstrb;
      dc_wr_ready = dn_wr_ready && !wr_pend;
   end

endmodule

// File: tb/tb_cache_mem_req_sched.sv
// Directed bench for cache_mem_req_sched: arbitration order, starvation
// relief, write/read line hazard, write throttling, beat gaps and reset.
module tb_cache_mem_req_sched;
   import cache_mem_req_sched_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ic_rd_req = 0, dc_rd_req = 0, dc_wr_req = 0;
   logic [31:0] ic_rd_addr = 0, dc_rd_addr = 0, dc_wr_addr = 0;
   logic [2:0] ic_rd_type = 0, dc_rd_type = 0, dc_wr_type = 0;
   logic [127:0] dc_wdata = 0;
   logic [7:0] dc_wstrb = 0;
   logic dn_rd_ready = 0, dn_rlast = 0, dn_rvalid = 0, dn_wr_ready = 0, dn_wr_bdone = 0;
   logic [63:0] dn_rdata = 0;
   logic ic_rd_ready, ic_rlast, ic_rvalid, dc_rd_ready, dc_rlast, dc_rvalid, dc_wr_ready;
   logic [63:0] ic_rdata, dc_rdata;
   logic dn_rd_req, dn_wr_req;
   logic [31:0] dn_rd_addr, dn_wr_addr;
   logic [2:0] dn_rd_type, dn_wr_type;
   logic [127:0] dn_wdata;
   logic [7:0] dn_wstrb;

   int errors = 0;
   int checks = 0;

   cache_mem_req_sched #(.STARVE_MAX(8), .LINE_OFS(4)) dut (
      .clk(clk), .rst(rst),
      .ic_rd_req(ic_rd_req), .ic_rd_addr(ic_rd_addr), .ic_rd_type(ic_rd_type),
      .ic_rd_ready(ic_rd_ready), .ic_rdata(ic_rdata), .ic_rlast(ic_rlast), .ic_rvalid(ic_rvalid),
      .dc_rd_req(dc_rd_req), .dc_rd_addr(dc_rd_addr), .dc_rd_type(dc_rd_type),
      .dc_rd_ready(dc_rd_ready), .dc_rdata(dc_rdata), .dc_rlast(dc_rlast), .dc_rvalid(dc_rvalid),
      .dc_wr_req(dc_wr_req), .dc_wr_addr(dc_wr_addr), .dc_wdata(dc_wdata),
      .dc_wr_type(dc_wr_type), .dc_wstrb(dc_wstrb), .dc_wr_ready(dc_wr_ready),
      .dn_rd_req(dn_rd_req), .dn_rd_addr(dn_rd_addr), .dn_rd_type(dn_rd_type),
      .dn_rd_ready(dn_rd_ready), .dn_rdata(dn_rdata), .dn_rlast(dn_rlast), .dn_rvalid(dn_rvalid),
      .dn_wr_req(dn_wr_req), .dn_wr_addr(dn_wr_addr), .dn_wdata(dn_wdata),
      .dn_wr_type(dn_wr_type), .dn_wstrb(dn_wstrb), .dn_wr_ready(dn_wr_ready),
      .dn_wr_bdone(dn_wr_bdone)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // advance one clock; inputs change 1ns after the edge, checks happen at +2ns
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   // Called in an IDLE cycle with requests already driven; runs one burst.
   task automatic burst(input logic is_d, input logic [31:0] addr, input int beats);
      step();
      dn_rd_ready = 1'b1;
      settle();
      chk("addr_req", dn_rd_req, 1'b1);
      chk("addr_owner", dn_rd_addr, addr);
      chk("owner_ready", is_d ? dc_rd_ready : ic_rd_ready, 1'b1);
      chk("other_ready", is_d ? ic_rd_ready : dc_rd_ready, 1'b0);
      step();
      dn_rd_ready = 1'b0;
      for (int b = 0; b < beats; b++) begin
         dn_rvalid = 1'b1;
         dn_rlast  = (b == beats - 1);
         dn_rdata  = {addr, 32'(b + 1)};
         settle();
         chk("owner_rvalid", is_d ? dc_rvalid : ic_rvalid, 1'b1);
         chk("owner_rdata", is_d ? dc_rdata : ic_rdata, {addr, 32'(b + 1)});
         chk("other_rvalid", is_d ? ic_rvalid : dc_rvalid, 1'b0);
         chk("other_rdata", is_d ? ic_rdata : dc_rdata, 64'h0);
         step();
      end
      dn_rvalid = 1'b0;
      dn_rlast  = 1'b0;
      dn_rdata  = '0;
   endtask

   initial begin
      // reset state
      step();
      step();
      settle();
      chk("rst_state", dut.state, RD_IDLE);
      chk("rst_starve", dut.starve_cnt, 0);
      chk("rst_wr_pend", dut.wr_pend, 1'b0);
      chk("rst_dn_rd_req", dn_rd_req, 1'b0);
      chk("rst_dn_rd_addr", dn_rd_addr, 32'h0);
      chk("rst_readys", {ic_rd_ready, dc_rd_ready, dc_wr_ready}, 3'b000);
      chk("rst_rvalid_rlast", {ic_rvalid, dc_rvalid, ic_rlast, dc_rlast}, 4'b0000);
      chk("rst_rdata", {ic_rdata, dc_rdata}, 128'h0);
      chk("rst_dn_wr_req", dn_wr_req, 1'b0);
      rst = 1'b0;
      step();

      // 1: simultaneous requests, D first then I
      ic_rd_req = 1; ic_rd_addr = 32'h0000_1000; ic_rd_type = RD_TYPE_LINE;
      dc_rd_req = 1; dc_rd_addr = 32'h0000_2000; dc_rd_type = RD_TYPE_LINE;
      settle();
      chk("t1_idle_no_req", dn_rd_req, 1'b0);
      burst(1'b1, 32'h0000_2000, 2);
      chk("t1_starve_after_d", dut.starve_cnt, 1);
      dc_rd_req = 0;
      burst(1'b0, 32'h0000_1000, 2);
      chk("t1_starve_after_i", dut.starve_cnt, 0);
      ic_rd_req = 0;
      step();
      settle();
      chk("t1_idle", dut.state, RD_IDLE);

      // 2: starvation relief after 8 D grants
      ic_rd_req = 1; dc_rd_req = 1;
      for (int g = 0; g < 8; g++) burst(1'b1, 32'h0000_2000, 2);
      chk("t2_starve_sat", dut.starve_cnt, 8);
      burst(1'b0, 32'h0000_1000, 2);
      chk("t2_starve_cleared", dut.starve_cnt, 0);
      burst(1'b1, 32'h0000_2000, 2);
      ic_rd_req = 0; dc_rd_req = 0;
      step();
      settle();
      chk("t2_starve_idle", dut.starve_cnt, 0);

      // 3: same-line hazard after an accepted write
      dc_wr_req = 1; dc_wr_addr = 32'h8000_0010; dc_wdata = 128'hA5A5_0000_1111_2222_3333_4444_5555_6666;
      dc_wr_type = RD_TYPE_B8; dc_wstrb = 8'hF0; dn_wr_ready = 1;
      settle();
      chk("t3_dn_wr_req", dn_wr_req, 1'b1);
      chk("t3_dn_wr_addr", dn_wr_addr, 32'h8000_0010);
      chk("t3_dn_wdata", dn_wdata, 128'hA5A5_0000_1111_2222_3333_4444_5555_6666);
      chk("t3_dn_wstrb", dn_wstrb, 8'hF0);
      chk("t3_dc_wr_ready", dc_wr_ready, 1'b1);
      step();
      dc_wr_req = 0; dn_wr_ready = 0;
      dc_rd_req = 1; dc_rd_addr = 32'h8000_0018; dc_rd_type = RD_TYPE_B8;
      for (int c = 0; c < 3; c++) begin
         settle();
         chk("t3_blocked", dn_rd_req, 1'b0);
         step();
      end
      chk("t3_blocked_idle", dut.state, RD_IDLE);
      dc_rd_addr = 32'h8000_0020;
      burst(1'b1, 32'h8000_0020, 1);
      dc_rd_addr = 32'h8000_0018;
      ic_rd_req = 1; ic_rd_addr = 32'h0000_3000;
      burst(1'b0, 32'h0000_3000, 1);
      ic_rd_req = 0;
      dn_wr_bdone = 1;
      settle();
      chk("t3_bdone_cycle", dn_rd_req, 1'b0);
      step();
      dn_wr_bdone = 0;
      settle();
      chk("t3_after_bdone_idle", dn_rd_req, 1'b0);
      chk("t3_wr_pend_clr", dut.wr_pend, 1'b0);
      burst(1'b1, 32'h8000_0018, 1);
      dc_rd_req = 0;
      step();

      // 4: second write throttled until bdone
      dc_wr_req = 1; dc_wr_addr = 32'h9000_0000; dn_wr_ready = 1;
      step();
      dc_wr_addr = 32'h9000_0040;
      for (int c = 0; c < 2; c++) begin
         settle();
         chk("t4_ready_gated", dc_wr_ready, 1'b0);
         chk("t4_req_gated", dn_wr_req, 1'b0);
         step();
      end
      dn_wr_bdone = 1;
      settle();
      chk("t4_bdone_ready", dc_wr_ready, 1'b0);
      step();
      dn_wr_bdone = 0;
      settle();
      chk("t4_accept_ready", dc_wr_ready, 1'b1);
      chk("t4_accept_req", dn_wr_req, 1'b1);
      chk("t4_accept_addr", dn_wr_addr, 32'h9000_0040);
      step();
      dc_wr_req = 0;
      settle();
      chk("t4_pend_again", dut.wr_pend, 1'b1);
      dn_wr_bdone = 1;
      step();
      dn_wr_bdone = 0;
      dn_wr_ready = 0;

      // 5: line read with gaps; leave D_DATA only on rlast beat
      dc_rd_req = 1; dc_rd_addr = 32'h0000_4000; dc_rd_type = RD_TYPE_LINE;
      step();
      settle();
      chk("t5_addr_wait_ready", dc_rd_ready, 1'b0);
      chk("t5_addr_wait_req", dn_rd_req, 1'b1);
      chk("t5_dn_rd_type", dn_rd_type, RD_TYPE_LINE);
      step();
      dn_rd_ready = 1;
      step();
      dn_rd_ready = 0; dc_rd_req = 0;
      dn_rlast = 1;
      settle();
      chk("t5_gap_rvalid", dc_rvalid, 1'b0);
      step();
      chk("t5_gap_stay", dut.state, D_DATA);
      dn_rlast = 0; dn_rvalid = 1; dn_rdata = 64'hDEAD_BEEF_0000_0001;
      settle();
      chk("t5_beat1_dc", dc_rdata, 64'hDEAD_BEEF_0000_0001);
      chk("t5_beat1_ic", {ic_rvalid, ic_rdata}, 65'h0);
      step();
      chk("t5_beat1_stay", dut.state, D_DATA);
      dn_rvalid = 0;
      step();
      dn_rvalid = 1; dn_rlast = 1; dn_rdata = 64'hDEAD_BEEF_0000_0002;
      settle();
      chk("t5_beat2_rlast", {dc_rvalid, dc_rlast}, 2'b11);
      step();
      dn_rvalid = 0; dn_rlast = 0; dn_rdata = 0;
      chk("t5_done_idle", dut.state, RD_IDLE);

      // owner dropping req in x_ADDR returns to idle
      ic_rd_req = 1; ic_rd_addr = 32'h0000_5000;
      step();
      ic_rd_req = 0;
      step();
      chk("t5_drop_idle", dut.state, RD_IDLE);

      // 6: reset during I_DATA with a write pending
      dc_wr_req = 1; dc_wr_addr = 32'h7000_0000; dn_wr_ready = 1;
      step();
      dc_wr_req = 0; dn_wr_ready = 0;
      ic_rd_req = 1; ic_rd_addr = 32'h0000_6000;
      step();
      dn_rd_ready = 1;
      step();
      ic_rd_req = 0; dn_rd_ready = 0;
      dn_rvalid = 1; dn_rdata = 64'h1234_5678_9ABC_DEF0;
      settle();
      chk("t6_pre_rvalid", ic_rvalid, 1'b1);
      chk("t6_pre_pend", dut.wr_pend, 1'b1);
      rst = 1;
      step();
      rst = 0;
      settle();
      chk("t6_state", dut.state, RD_IDLE);
      chk("t6_outputs", {ic_rvalid, ic_rdata, dc_rvalid, dn_rd_req, ic_rd_ready}, 69'h0);
      chk("t6_wr_pend", dut.wr_pend, 1'b0);
      dn_wr_ready = 1;
      settle();
      chk("t6_wr_ready_follow1", dc_wr_ready, 1'b1);
      dn_wr_ready = 0;
      settle();
      chk("t6_wr_ready_follow0", dc_wr_ready, 1'b0);
      dn_rvalid = 0;
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
